// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder for the MEM-stage data-memory interface of the multi-cycle CPU.
//   It takes one load/store request at a time over a valid/ready handshake,
//   waits WAIT_CYCLES cycles, commits the access, then pulses o_resp_valid
//   for one cycle. A separate registered debug port reads the array for the
//   display path. It never stalls and never disturbs the request path.
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_wen, i_req_addr, i_req_wdata
//                         request handshake and fields (wen==0 means read)
//   o_resp_valid, o_resp_rdata, o_resp_err
//                         one-cycle response, read word, out-of-range flag
//   o_busy                high while a request is in flight (WAIT/RESP)
//   i_dbg_addr, o_dbg_rdata
//                         display read port, one cycle of latency
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_busy,
    input  logic [31:0] i_dbg_addr,
    output logic [31:0] o_dbg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [2:0] CNT_INIT  = ZERO_WAIT ? 3'd0 : 3'(WAIT_CYCLES - 1);

    logic [31:0]       r_mem [0:DEPTH-1];
    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [3:0]        r_wen;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic              r_oor;
    logic              r_ready;
    logic              r_busy;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [31:0]       r_dbg_rdata;

    logic              w_req_oor;
    logic              w_dbg_oor;
    logic              w_cm_en;
    logic [3:0]        w_cm_wen;
    logic [ADDR_W-1:0] w_cm_idx;
    logic [31:0]       w_cm_wdata;
    logic              w_cm_oor;
    logic [31:0]       w_cm_rdata;
    logic              w_unused_addr_lsbs;

    // Byte-offset bits never select anything; word addressing only.
    assign w_unused_addr_lsbs = ^{i_req_addr[1:0], i_dbg_addr[1:0]};

    assign w_req_oor = |i_req_addr[31:ADDR_W+2];
    assign w_dbg_oor = |i_dbg_addr[31:ADDR_W+2];

    // Select the access committed this edge. With zero wait states the commit
    // happens on the accept edge itself, so the live request fields are used.
    always_comb begin
        w_cm_en    = 1'b0;
        w_cm_wen   = r_wen;
        w_cm_idx   = r_idx;
        w_cm_wdata = r_wdata;
        w_cm_oor   = r_oor;
        if (i_reset) begin
            w_cm_en = 1'b0;
        end else if (r_state == ST_WAIT && r_cnt == 3'd0) begin
            w_cm_en = 1'b1;
        end else if (r_state == ST_IDLE && i_req_valid && ZERO_WAIT) begin
            w_cm_en    = 1'b1;
            w_cm_wen   = i_req_wen;
            w_cm_idx   = i_req_addr[ADDR_W+1:2];
            w_cm_wdata = i_req_wdata;
            w_cm_oor   = w_req_oor;
        end else begin
            w_cm_en = 1'b0;
        end
        w_cm_rdata = w_cm_oor ? 32'h0000_0000 : r_mem[w_cm_idx];
    end

    // Array write port; out-of-range writes never land.
    always_ff @(posedge i_clk) begin
        if (w_cm_en && !w_cm_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w_cm_wen[i]) begin
                    r_mem[w_cm_idx][8*i +: 8] <= w_cm_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_wen        <= 4'b0000;
            r_idx        <= '0;
            r_wdata      <= 32'h0000_0000;
            r_oor        <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (i_req_valid) begin
                        r_wen   <= i_req_wen;
                        r_idx   <= i_req_addr[ADDR_W+1:2];
                        r_wdata <= i_req_wdata;
                        r_oor   <= w_req_oor;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (ZERO_WAIT) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_cm_oor;
                            if (w_cm_wen == 4'b0000) begin
                                r_resp_rdata <= w_cm_rdata;
                            end
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_cm_oor;
                        if (w_cm_wen == 4'b0000) begin
                            r_resp_rdata <= w_cm_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Debug read; a same-edge commit shows up here one cycle later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dbg_rdata <= 32'h0000_0000;
        end else begin
            r_dbg_rdata <= w_dbg_oor ? 32'h0000_0000 : r_mem[i_dbg_addr[ADDR_W+1:2]];
        end
    end

    assign o_req_ready  = r_ready;
    assign o_busy       = r_busy;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_wen = 4'b0000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] dbg_addr = 32'h0;
    logic [31:0] dbg_rdata;

    logic        v0 = 1'b0;
    logic        ready0;
    logic [3:0]  wen0 = 4'b0000;
    logic [31:0] addr0 = 32'h0;
    logic [31:0] wdata0 = 32'h0;
    logic        rv0;
    logic [31:0] rd0;
    logic        err0;
    logic        busy0;
    logic [31:0] dbga0 = 32'h0;
    logic [31:0] dbgd0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_busy(busy), .i_dbg_addr(dbg_addr), .o_dbg_rdata(dbg_rdata)
    );

    data_mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(v0), .o_req_ready(ready0),
        .i_req_wen(wen0), .i_req_addr(addr0), .i_req_wdata(wdata0),
        .o_resp_valid(rv0), .o_resp_rdata(rd0), .o_resp_err(err0),
        .o_busy(busy0), .i_dbg_addr(dbga0), .o_dbg_rdata(dbgd0)
    );

    // Issue one request on the WAIT_CYCLES=2 instance; lat counts edges from
    // accept to the edge that first samples resp_valid high (99 = timeout).
    task automatic do_req(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rdata, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = addr ^ 32'h0000_0004;
        req_wdata = ~wdata;
        lat   = 99;
        rdata = 32'h0;
        err   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat   = k + 1;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 6;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_dbg_rdata got=%h exp=0", dbg_rdata); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic er;
        do_req(4'hF, 32'h10, 32'h1122_3344, lat, rd, er);
        total += 3;
        if (lat != 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
        if (er !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", er); end
        @(negedge clk);
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse_width got=%b exp=0", resp_valid); end
        do_req(4'h0, 32'h10, 32'h0, lat, rd, er);
        total += 3;
        if (lat != 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        if (rd !== 32'h1122_3344) begin bad++; $display("FAIL rd_data got=%h exp=11223344", rd); end
        if (er !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic er;
        do_req(4'b0010, 32'h10, 32'hAABB_CCDD, lat, rd, er);
        total += 1;
        if (resp_rdata !== 32'h1122_3344) begin bad++; $display("FAIL be_write_keeps_rdata got=%h exp=11223344", resp_rdata); end
        do_req(4'h0, 32'h10, 32'h0, lat, rd, er);
        total += 1;
        if (rd !== 32'h1122_CC44) begin bad++; $display("FAIL be_read got=%h exp=1122cc44", rd); end
    endtask

    task automatic test_back_to_back();
        int n, ones, pulses, run, maxrun;
        n = 0; ones = 0; pulses = 0; run = 0; maxrun = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_wen   = 4'h0;
        req_addr  = 32'h10;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (req_ready === 1'b1) begin ones++; run = 0; end
            else begin run++; if (run > maxrun) maxrun = run; end
            if (resp_valid === 1'b1) pulses++;
        end
        req_valid = 1'b0;
        total += 3;
        if (maxrun != 3) begin bad++; $display("FAIL b2b_ready_low_run got=%0d exp=3", maxrun); end
        if (ones != 3) begin bad++; $display("FAIL b2b_ready_high_cycles got=%0d exp=3", ones); end
        if (pulses != 3) begin bad++; $display("FAIL b2b_resp_count got=%0d exp=3", pulses); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er;
        do_req(4'hF, 32'h0, 32'hCAFE_F00D, lat, rd, er);
        do_req(4'hF, 32'h400, 32'hDEAD_BEEF, lat, rd, er);
        total += 1;
        if (er !== 1'b1) begin bad++; $display("FAIL oor_write_err got=%b exp=1", er); end
        do_req(4'h0, 32'h0, 32'h0, lat, rd, er);
        total += 2;
        if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL oor_word0_kept got=%h exp=cafef00d", rd); end
        if (er !== 1'b0) begin bad++; $display("FAIL oor_word0_err got=%b exp=0", er); end
        do_req(4'h0, 32'h400, 32'h0, lat, rd, er);
        total += 2;
        if (rd !== 32'h0) begin bad++; $display("FAIL oor_read_data got=%h exp=0", rd); end
        if (er !== 1'b1) begin bad++; $display("FAIL oor_read_err got=%b exp=1", er); end
    endtask

    task automatic test_reset_midwrite();
        int lat, n, pulses; logic [31:0] rd; logic er;
        do_req(4'hF, 32'h20, 32'h0000_0005, lat, rd, er);
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_wen = 4'hF; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy got=%b exp=1", busy); end
        if (req_ready !== 1'b0) begin bad++; $display("FAIL wait_ready got=%b exp=0", req_ready); end
        reset = 1'b1;
        #1;
        total += 2;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_resp_valid got=%b exp=0", resp_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total += 1;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        total += 1;
        if (pulses != 0) begin bad++; $display("FAIL rst_stray_resp got=%0d exp=0", pulses); end
        do_req(4'h0, 32'h20, 32'h0, lat, rd, er);
        total += 1;
        if (rd !== 32'h0000_0005) begin bad++; $display("FAIL rst_discard_write got=%h exp=00000005", rd); end
    endtask

    task automatic test_debug();
        dbg_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        total += 1;
        if (dbg_rdata !== 32'h1122_CC44) begin bad++; $display("FAIL dbg_read got=%h exp=1122cc44", dbg_rdata); end
        dbg_addr = 32'h400;
        @(posedge clk);
        @(negedge clk);
        total += 1;
        if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL dbg_oor got=%h exp=0", dbg_rdata); end
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        dbga0 = 32'h8;
        v0 = 1'b1; wen0 = 4'hF; addr0 = 32'h8; wdata0 = 32'h0000_0001;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        total += 1;
        if (rv0 !== 1'b1) begin bad++; $display("FAIL zw_first_latency got=%b exp=1", rv0); end
        @(negedge clk);
        total += 2;
        if (rv0 !== 1'b0) begin bad++; $display("FAIL zw_pulse_width got=%b exp=0", rv0); end
        if (ready0 !== 1'b1) begin bad++; $display("FAIL zw_ready got=%b exp=1", ready0); end
        v0 = 1'b1; wdata0 = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        total += 2;
        if (rv0 !== 1'b1) begin bad++; $display("FAIL zw_latency got=%b exp=1", rv0); end
        if (dbgd0 !== 32'h0000_0001) begin bad++; $display("FAIL zw_dbg_old got=%h exp=00000001", dbgd0); end
        @(negedge clk);
        total += 1;
        if (dbgd0 !== 32'h0BAD_F00D) begin bad++; $display("FAIL zw_dbg_new got=%h exp=0badf00d", dbgd0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_reset_midwrite();
        test_debug();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
